// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator and its saturating adder.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W    = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_CNT_W = 4;

  // All-ones value of a w-bit unsigned word.
  function automatic logic [63:0] satmax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned ACC_W + 8-bit adder that clamps to the all-ones value on overflow.
module sat_adder
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(satmax(ACC_W));

  // One extra bit catches the carry out; ACC_W >= PROD_W keeps the pad width legal.
  logic [ACC_W:0] raw_sum;

  assign raw_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign ovf     = raw_sum[ACC_W];
  assign sum     = ovf ? ACC_MAX : raw_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of 8-bit products into a saturating sum and
// presents it on a valid/ready output.
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              sat,
  output logic              busy,
  output logic [CNT_W-1:0]  term_cnt
);

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] n_reg;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             last_term;

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .acc  (acc_reg),
    .prod (prod_in),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // Handshake status is decoded from state alone so no input reaches an output.
  assign prod_ready = (state_reg == ACCUM);
  assign sum_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign last_term  = (term_cnt == n_reg - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      n_reg     <= '0;
      term_cnt  <= '0;
      sum_out   <= '0;
      sat       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg  <= '0;
            term_cnt <= '0;
            sat      <= 1'b0;
            n_reg    <= n_terms;
            if (n_terms == '0) begin
              sum_out   <= '0;
              state_reg <= DONE;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_reg  <= add_sum;
            term_cnt <= term_cnt + CNT_W'(1);
            if (add_ovf) sat <= 1'b1;
            if (last_term) begin
              sum_out   <= add_sum;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (sum_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a cycle-level reference model.
module tb_product_accumulator;

  localparam int ACC_W = 10;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_terms = '0;
  logic [7:0]       prod_in = '0;
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [ACC_W-1:0] sum_out;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic             sat;
  logic             busy;
  logic [CNT_W-1:0] term_cnt;

  int n_checks = 0;
  int n_errors = 0;

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_terms    (n_terms),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sat        (sat),
    .busy       (busy),
    .term_cnt   (term_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 waiting, 1 collecting terms, 2 result on offer.
  int m_phase, m_acc, m_cnt, m_n, m_sum;
  bit m_sat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_acc = 0; m_cnt = 0; m_n = 0; m_sum = 0; m_sat = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_acc = 0; m_cnt = 0; m_sat = 0;
          if (n_terms == 0) begin
            m_sum = 0; m_phase = 2;
          end else begin
            m_n = n_terms; m_phase = 1;
          end
        end
        1: if (prod_valid) begin
          m_acc = m_acc + int'(prod_in);
          if (m_acc > MAXV) begin
            m_acc = MAXV; m_sat = 1;
          end
          m_cnt++;
          if (m_cnt == m_n) begin
            m_sum = m_acc; m_phase = 2;
          end
        end
        default: if (sum_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_busy", busy, int'(m_phase != 0));
      chk("model_prod_ready", prod_ready, int'(m_phase == 1));
      chk("model_sum_valid", sum_valid, int'(m_phase == 2));
      chk("model_sat", sat, m_sat);
      chk("model_term_cnt", term_cnt, m_cnt);
      if (m_phase == 2) chk("model_sum_out", sum_out, m_sum);
    end
  end

  // All stimulus tasks begin and end just after a falling edge.
  task automatic start_run(input int n);
    start = 1'b1;
    n_terms = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    n_terms = 4'hF;
  endtask

  task automatic send(input int p, input int gap);
    prod_valid = 1'b1;
    prod_in = 8'(p);
    @(negedge clk);
    prod_valid = 1'b0;
    prod_in = 8'hAA;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !sum_valid; i++) @(negedge clk);
    chk(name, sum_valid, 1);
  endtask

  task automatic drain();
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a run
    start_run(4);
    send(6, 0);
    send(7, 0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_prod_ready", prod_ready, 0);
    chk("midrst_sum_valid", sum_valid, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_term_cnt", term_cnt, 0);
    chk("midrst_sum_out", sum_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(1);
    send(9, 0);
    wait_done("fresh_done");
    chk("fresh_sum", sum_out, 9);
    drain();

    // Back-to-back products; result visible one edge after the last handshake
    start_run(3);
    send(6, 0);
    send(15, 0);
    send(225, 0);
    chk("basic_valid_latency", sum_valid, 1);
    chk("basic_sum", sum_out, 246);
    chk("basic_sat", sat, 0);
    chk("basic_term_cnt", term_cnt, 3);

    // Output stall with start and prod_valid pulsed
    start = 1'b1;
    n_terms = 4'd2;
    prod_valid = 1'b1;
    prod_in = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", sum_valid, 1);
      chk("stall_sum", sum_out, 246);
      chk("stall_prod_ready", prod_ready, 0);
    end
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sum_ready = 1'b0;
    chk("stall_release_valid", sum_valid, 0);
    chk("stall_release_busy", busy, 0);
    @(negedge clk);
    chk("start_at_done_ignored", busy, 0);

    // Gaps between products
    start_run(4);
    for (int i = 1; i <= 4; i++) send(i, 2);
    wait_done("gap_done");
    chk("gap_sum", sum_out, 10);
    chk("gap_term_cnt", term_cnt, 4);
    drain();

    // Saturation at 1023
    start_run(5);
    for (int i = 0; i < 5; i++) send(225, 0);
    wait_done("sat_done");
    chk("sat_sum", sum_out, 1023);
    chk("sat_flag", sat, 1);
    drain();
    chk("sat_sticky_idle", sat, 1);
    start_run(1);
    send(7, 0);
    wait_done("post_sat_done");
    chk("post_sat_sum", sum_out, 7);
    chk("post_sat_flag", sat, 0);
    drain();

    // Zero terms
    start_run(0);
    chk("zero_valid", sum_valid, 1);
    chk("zero_sum", sum_out, 0);
    chk("zero_sat", sat, 0);
    chk("zero_prod_ready", prod_ready, 0);
    drain();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
